// File: rtl/byte_striping_pkg.sv
// Shared types for the byte unstriping path: lane-group entry and serializer state.
// No logic of its own; helper functions are pure combinational mask decoders.
// No backpressure here; flow control lives in byte_unstriping and unstripe_fifo.
package byte_striping_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_W     = 8;
    localparam int LANE_IDX_W = 2;

    // One buffered lane group: lane bytes plus the per-lane valid mask.
    typedef struct packed {
        logic [NUM_LANES-1:0][LANE_W-1:0] data;
        logic [NUM_LANES-1:0]             mask;
    } lane_grp_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Index of the lowest set bit; returns 0 for an all-zero mask.
    function automatic logic [LANE_IDX_W-1:0] first_lane(input logic [NUM_LANES-1:0] mask);
        logic [LANE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) idx = LANE_IDX_W'(i);
        end
        return idx;
    endfunction

    // Mask of lanes strictly above idx (all zero when idx is the top lane).
    function automatic logic [NUM_LANES-1:0] lanes_above(input logic [LANE_IDX_W-1:0] idx);
        return ~((NUM_LANES'(2) << idx) - NUM_LANES'(1));
    endfunction

endpackage

// File: rtl/unstripe_fifo.sv
// Circular FIFO of lane-group entries with registered occupancy count.
// Write lands on the push edge; head is readable the cycle after (no bypass).
// Push is refused only when full with no same-cycle pop; pop is ignored when empty.
module unstripe_fifo
    import byte_striping_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk1Mhz,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  lane_grp_t wdata,
    output lane_grp_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    lane_grp_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk1Mhz) begin
        if (!reset && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/byte_unstriping.sv
// Reassembles striped lane groups into one byte stream, lane 0 first, skipping invalid lanes.
// Group sampled at edge N shows its first byte after edge N+1 (FIFO empty, serializer idle).
// Output holds while outReady=0; a full FIFO drops new groups (sticky overflowErr).
// Optional BYTE_UNSTRIPING_STATS_EN adds a 16-bit wrapping count of accepted bytes.
module byte_unstriping
    import byte_striping_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int LANE_W = 8
) (
    input  logic              clk1Mhz,
    input  logic              reset,
    input  logic [LANE_W-1:0] stripedLane0,
    input  logic [LANE_W-1:0] stripedLane1,
    input  logic [LANE_W-1:0] stripedLane2,
    input  logic [LANE_W-1:0] stripedLane3,
    input  logic              lane0VLD,
    input  logic              lane1VLD,
    input  logic              lane2VLD,
    input  logic              lane3VLD,
    input  logic              byteStripingVLD,
    input  logic              outReady,
    output logic [LANE_W-1:0] unstripedOUT,
    output logic              unstripedVLD,
    output logic              fifoFull,
    output logic              overflowErr,
    output logic [1:0]        counter
`ifdef BYTE_UNSTRIPING_STATS_EN
    ,
    output logic [15:0]       byteCount
`endif
);

    ser_state_t               state;
    lane_grp_t                grp_in;
    lane_grp_t                head;
    lane_grp_t                cur;
    logic                     push_req;
    logic                     pop_req;
    logic                     fifo_empty;
    logic                     accept;
    logic [NUM_LANES-1:0]     above;
    logic                     has_next;
    logic [LANE_IDX_W-1:0]    next_idx;
    logic [LANE_IDX_W-1:0]    head_idx;

    // Pack the incoming lanes into a group entry.
    always_comb begin
        grp_in.data[0] = stripedLane0;
        grp_in.data[1] = stripedLane1;
        grp_in.data[2] = stripedLane2;
        grp_in.data[3] = stripedLane3;
        grp_in.mask    = {lane3VLD, lane2VLD, lane1VLD, lane0VLD};
    end

    // An all-invalid group carries nothing, so it is never pushed (and never overflows).
    assign push_req = byteStripingVLD && (|grp_in.mask);
    assign accept   = (state == SEND) && unstripedVLD && outReady;
    assign above    = cur.mask & lanes_above(counter);
    assign has_next = |above;
    assign next_idx = first_lane(above);
    assign head_idx = first_lane(head.mask);
    // Pop when idle, or when the last valid lane of the current group is leaving.
    assign pop_req  = !fifo_empty && ((state == IDLE) || (accept && !has_next));

    unstripe_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1Mhz (clk1Mhz),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop_req),
        .wdata   (grp_in),
        .rdata   (head),
        .full    (fifoFull),
        .empty   (fifo_empty)
    );

    // Serializer: walk the valid lanes of the current group, chaining into the next group without a bubble.
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            state        <= IDLE;
            cur          <= '0;
            unstripedOUT <= '0;
            unstripedVLD <= 1'b0;
            counter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur          <= head;
                        counter      <= head_idx;
                        unstripedOUT <= head.data[head_idx];
                        unstripedVLD <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (has_next) begin
                            counter      <= next_idx;
                            unstripedOUT <= cur.data[next_idx];
                        end else if (!fifo_empty) begin
                            cur          <= head;
                            counter      <= head_idx;
                            unstripedOUT <= head.data[head_idx];
                        end else begin
                            unstripedVLD <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky drop flag: a real group arrived while full and nothing left the FIFO.
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            overflowErr <= 1'b0;
        end else if (push_req && fifoFull && !pop_req) begin
            overflowErr <= 1'b1;
        end
    end

`ifdef BYTE_UNSTRIPING_STATS_EN
    // Accepted-byte counter, wraps at 16 bits.
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            byteCount <= '0;
        end else if (accept) begin
            byteCount <= byteCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: ordering, lane skipping, stalls, overflow, throughput, reset.
// Inputs are driven 1 time unit after each rising edge and outputs sampled at the same point.
// Expected bytes come from hand-written constants and a bench-side queue.
module tb_byte_unstriping;

    logic        clk1Mhz = 1'b0;
    logic        reset;
    logic [7:0]  stripedLane0, stripedLane1, stripedLane2, stripedLane3;
    logic        lane0VLD, lane1VLD, lane2VLD, lane3VLD;
    logic        byteStripingVLD;
    logic        outReady;
    logic [7:0]  unstripedOUT;
    logic        unstripedVLD;
    logic        fifoFull;
    logic        overflowErr;
    logic [1:0]  counter;
`ifdef BYTE_UNSTRIPING_STATS_EN
    logic [15:0] byteCount;
`endif

    int          checks = 0;
    int          errors = 0;
    int          gaps = 0;
    int          bytes_seen = 0;
    bit          watch_gaps = 1'b0;
    bit          seen = 1'b0;
    logic [7:0]  exp_q [$];

    always #5 clk1Mhz = ~clk1Mhz;

    byte_unstriping #(
        .DEPTH  (4),
        .LANE_W (8)
    ) dut (
        .clk1Mhz         (clk1Mhz),
        .reset           (reset),
        .stripedLane0    (stripedLane0),
        .stripedLane1    (stripedLane1),
        .stripedLane2    (stripedLane2),
        .stripedLane3    (stripedLane3),
        .lane0VLD        (lane0VLD),
        .lane1VLD        (lane1VLD),
        .lane2VLD        (lane2VLD),
        .lane3VLD        (lane3VLD),
        .byteStripingVLD (byteStripingVLD),
        .outReady        (outReady),
        .unstripedOUT    (unstripedOUT),
        .unstripedVLD    (unstripedVLD),
        .fifoFull        (fifoFull),
        .overflowErr     (overflowErr),
        .counter         (counter)
`ifdef BYTE_UNSTRIPING_STATS_EN
        ,
        .byteCount       (byteCount)
`endif
    );

    task automatic tick();
        @(posedge clk1Mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_grp(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [3:0] m);
        stripedLane0    = b0;
        stripedLane1    = b1;
        stripedLane2    = b2;
        stripedLane3    = b3;
        {lane3VLD, lane2VLD, lane1VLD, lane0VLD} = m;
        byteStripingVLD = 1'b1;
    endtask

    task automatic idle_in();
        byteStripingVLD = 1'b0;
        {lane3VLD, lane2VLD, lane1VLD, lane0VLD} = 4'b0000;
    endtask

    function automatic logic [7:0] gb(input int k, input int l);
        return 8'(8'h80 + k * 16 + l);
    endfunction

    // Advance one cycle (outReady assumed 1) and score whatever byte is presented.
    task automatic step();
        logic [7:0] e;
        tick();
        if (unstripedVLD) begin
            seen = 1'b1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                bytes_seen++;
                chk("stream_byte", {24'b0, unstripedOUT}, {24'b0, e});
            end else begin
                chk("stale_byte_vld", {31'b0, unstripedVLD}, 32'd0);
            end
        end else if (watch_gaps && seen && exp_q.size() != 0) begin
            gaps++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        outReady = 1'b1;
        stripedLane0 = '0; stripedLane1 = '0; stripedLane2 = '0; stripedLane3 = '0;
        idle_in();
        tick();
        tick();
        chk("rst_vld", {31'b0, unstripedVLD}, 32'd0);
        chk("rst_out", {24'b0, unstripedOUT}, 32'd0);
        chk("rst_counter", {30'b0, counter}, 32'd0);
        chk("rst_full", {31'b0, fifoFull}, 32'd0);
        chk("rst_ovf", {31'b0, overflowErr}, 32'd0);
        reset = 1'b0;
        tick();

        // Four valid lanes: 11,22,33,44 starting one cycle after the sample edge.
        set_grp(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111);
        tick();
        idle_in();
        chk("t1_not_yet_vld", {31'b0, unstripedVLD}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_vld", {31'b0, unstripedVLD}, 32'd1);
            chk("t1_byte", {24'b0, unstripedOUT}, 32'(8'h11 * (i + 1)));
            chk("t1_counter", {30'b0, counter}, 32'(i));
        end
        tick();
        chk("t1_end_vld", {31'b0, unstripedVLD}, 32'd0);

        // Mask 1010: only lanes 1 and 3, back to back.
        set_grp(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1010);
        tick();
        idle_in();
        tick();
        chk("t2_b0", {24'b0, unstripedOUT}, 32'hA1);
        chk("t2_c0", {30'b0, counter}, 32'd1);
        tick();
        chk("t2_vld1", {31'b0, unstripedVLD}, 32'd1);
        chk("t2_b1", {24'b0, unstripedOUT}, 32'hA3);
        chk("t2_c1", {30'b0, counter}, 32'd3);
        tick();
        chk("t2_end_vld", {31'b0, unstripedVLD}, 32'd0);

        // All-invalid group is ignored.
        set_grp(8'h55, 8'h56, 8'h57, 8'h58, 4'b0000);
        tick();
        idle_in();
        tick();
        chk("zero_mask_vld", {31'b0, unstripedVLD}, 32'd0);
        tick();
        chk("zero_mask_vld2", {31'b0, unstripedVLD}, 32'd0);
        chk("zero_mask_ovf", {31'b0, overflowErr}, 32'd0);

        // Stall three cycles on lane 1.
        set_grp(8'h51, 8'h52, 8'h53, 8'h54, 4'b1111);
        tick();
        idle_in();
        tick();
        chk("t3_b0", {24'b0, unstripedOUT}, 32'h51);
        tick();
        chk("t3_b1", {24'b0, unstripedOUT}, 32'h52);
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_hold_byte", {24'b0, unstripedOUT}, 32'h52);
            chk("t3_hold_cnt", {30'b0, counter}, 32'd1);
            chk("t3_hold_vld", {31'b0, unstripedVLD}, 32'd1);
        end
        outReady = 1'b1;
        tick();
        chk("t3_b2", {24'b0, unstripedOUT}, 32'h53);
        chk("t3_c2", {30'b0, counter}, 32'd2);
        tick();
        chk("t3_b3", {24'b0, unstripedOUT}, 32'h54);
        tick();
        chk("t3_end_vld", {31'b0, unstripedVLD}, 32'd0);

        // Overflow: group 0 goes into the serializer, groups 1..4 fill the FIFO, group 5 is dropped.
        outReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_grp(gb(k, 0), gb(k, 1), gb(k, 2), gb(k, 3), 4'b1111);
            tick();
            if (k == 3) chk("t4_not_full_yet", {31'b0, fifoFull}, 32'd0);
        end
        chk("t4_full", {31'b0, fifoFull}, 32'd1);
        chk("t4_no_ovf_yet", {31'b0, overflowErr}, 32'd0);
        set_grp(gb(5, 0), gb(5, 1), gb(5, 2), gb(5, 3), 4'b1111);
        tick();
        idle_in();
        chk("t4_ovf", {31'b0, overflowErr}, 32'd1);
        chk("t4_full_after_drop", {31'b0, fifoFull}, 32'd1);
        chk("t4_stalled_byte", {24'b0, unstripedOUT}, {24'b0, gb(0, 0)});
        outReady = 1'b1;
        for (int l = 1; l < 4; l++) begin
            tick();
            chk("t4_g0_byte", {24'b0, unstripedOUT}, {24'b0, gb(0, l)});
        end
        // Push while full on the same edge the head is popped: accepted.
        set_grp(gb(6, 0), gb(6, 1), gb(6, 2), gb(6, 3), 4'b1111);
        tick();
        idle_in();
        chk("t4_full_push_pop", {31'b0, fifoFull}, 32'd1);
        chk("t4_g1_first", {24'b0, unstripedOUT}, {24'b0, gb(1, 0)});
        for (int l = 1; l < 4; l++) exp_q.push_back(gb(1, l));
        for (int k = 2; k < 5; k++)
            for (int l = 0; l < 4; l++) exp_q.push_back(gb(k, l));
        for (int l = 0; l < 4; l++) exp_q.push_back(gb(6, l));
        drain(100);
        tick();
        chk("t4_drained_vld", {31'b0, unstripedVLD}, 32'd0);
        chk("t4_ovf_sticky", {31'b0, overflowErr}, 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_ovf", {31'b0, overflowErr}, 32'd0);
        chk("rst2_full", {31'b0, fifoFull}, 32'd0);

        // Throughput: 64 full groups, one every 4 cycles.
        watch_gaps = 1'b1;
        seen = 1'b0;
        gaps = 0;
        bytes_seen = 0;
        for (int g = 0; g < 64; g++) begin
            set_grp(8'(4 * g), 8'(4 * g + 1), 8'(4 * g + 2), 8'(4 * g + 3), 4'b1111);
            for (int l = 0; l < 4; l++) exp_q.push_back(8'(4 * g + l));
            step();
            idle_in();
            step();
            step();
            step();
        end
        drain(50);
        watch_gaps = 1'b0;
        tick();
        chk("t5_end_vld", {31'b0, unstripedVLD}, 32'd0);
        chk("t5_gaps", gaps, 32'd0);
        chk("t5_bytes", bytes_seen, 32'd256);
        chk("t5_ovf", {31'b0, overflowErr}, 32'd0);
`ifdef BYTE_UNSTRIPING_STATS_EN
        chk("t5_byteCount", {16'b0, byteCount}, 32'd256);
`endif

        // Reset during SEND with two groups buffered.
        outReady = 1'b0;
        set_grp(8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b1111);
        tick();
        set_grp(8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'b1111);
        tick();
        set_grp(8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'b1111);
        tick();
        idle_in();
        chk("t6_sending", {31'b0, unstripedVLD}, 32'd1);
        chk("t6_sending_byte", {24'b0, unstripedOUT}, 32'hC0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_vld", {31'b0, unstripedVLD}, 32'd0);
        chk("t6_rst_full", {31'b0, fifoFull}, 32'd0);
        chk("t6_rst_out", {24'b0, unstripedOUT}, 32'd0);
        chk("t6_rst_cnt", {30'b0, counter}, 32'd0);
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_stale", {31'b0, unstripedVLD}, 32'd0);
        end
        set_grp(8'hF0, 8'hF1, 8'hF2, 8'hF3, 4'b1111);
        tick();
        idle_in();
        for (int l = 0; l < 4; l++) exp_q.push_back(8'(8'hF0 + l));
        drain(20);
        tick();
        chk("t6_end_vld", {31'b0, unstripedVLD}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
